// File: rtl/mutative_writeback_buffer_pkg.sv
// Shared types for the mutative cache victim path: cache line/address layouts
// and the write-back FIFO entry format.
package mutative_writeback_buffer_pkg;
  localparam int CACHELINE_SIZE = 256;
  localparam int TAG_BITS       = 20;
  localparam int SET_BITS       = 7;
  localparam int OFFSET_BITS    = 5;
  localparam int MEM_DATA_WIDTH = 64;
  localparam int BEATS          = CACHELINE_SIZE / MEM_DATA_WIDTH;
  localparam int BEAT_BITS      = $clog2(BEATS);

  typedef struct packed {
    logic                      valid;
    logic                      dirty;
    logic [TAG_BITS-1:0]       tag;
    logic [CACHELINE_SIZE-1:0] data;
  } cache_output_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [SET_BITS-1:0]    set_index;
    logic [OFFSET_BITS-1:0] offset;
  } cache_address_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]       tag;
    logic [SET_BITS-1:0]       set_index;
    logic [CACHELINE_SIZE-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/mutative_wb_fifo.sv
// Circular FIFO of write-back entries; every slot's tag/set and occupancy are
// exported so the owner can snoop all queued lines in parallel.
module mutative_wb_fifo
  import mutative_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  wb_entry_t                        din_i,
  output wb_entry_t                        head_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [DEPTH-1:0]                 occupied_o,
  output logic [DEPTH-1:0][TAG_BITS-1:0]   tag_o,
  output logic [DEPTH-1:0][SET_BITS-1:0]   set_o
);
  localparam int PTR_BITS = $clog2(DEPTH);

  wb_entry_t             mem_q [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]     count_q, count_d;
  logic [DEPTH-1:0]      occ_q, occ_d;

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    occ_d = occ_q;
    if (pop_i)  occ_d[rd_ptr_q] = 1'b0;
    if (push_i) occ_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign full_o     = (count_q == (PTR_BITS+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign occupied_o = occ_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign tag_o[gi] = mem_q[gi].tag;
    assign set_o[gi] = mem_q[gi].set_index;
  end
endmodule

// File: rtl/mutative_writeback_buffer.sv
// Victim write-back buffer: filters dirty victims into a FIFO, drains each as a
// multi-beat memory write burst and answers line-address snoops.
module mutative_writeback_buffer
  import mutative_writeback_buffer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int MEM_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      evict_valid,
  output logic                      evict_ready,
  input  cache_output_t             evict_line,
  input  logic [SET_BITS-1:0]       evict_set,
  output logic                      mem_wvalid,
  input  logic                      mem_wready,
  output logic                      mem_wlast,
  output logic [31:0]               mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [31:0]               snoop_addr,
  output logic                      snoop_hit,
  output logic                      empty
);
  localparam int NBEATS     = CACHELINE_SIZE / MEM_DATA_WIDTH;
  localparam int NBEAT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [NBEAT_BITS-1:0] LAST_BEAT = NBEAT_BITS'(NBEATS - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic                             push, pop, fifo_full, fifo_empty;
  wb_entry_t                        push_entry, head;
  logic [DEPTH-1:0]                 occupied, hit_vec;
  logic [DEPTH-1:0][TAG_BITS-1:0]   ent_tag;
  logic [DEPTH-1:0][SET_BITS-1:0]   ent_set;
  logic [0:0]                       state_q, state_d;
  logic [NBEAT_BITS-1:0]            beat_q, beat_d, beat_inc;
  logic [31:0]                      addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic                             last_beat;
  logic                             snoop_offset_unused;

  // Clean or invalid victims still complete the handshake but are dropped.
  assign evict_ready = !fifo_full;
  assign push        = evict_valid && evict_ready && evict_line.valid && evict_line.dirty;
  assign push_entry  = {evict_line.tag, evict_set, evict_line.data};

  mutative_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .din_i      (push_entry),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .occupied_o (occupied),
    .tag_o      (ent_tag),
    .set_o      (ent_set)
  );

  assign beat_inc  = beat_q + 1'b1;
  assign last_beat = (beat_q == LAST_BEAT);

  // Address and beat data are registered so they hold through stalls and idle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_BURST;
          beat_d  = '0;
          addr_d  = {head.tag, head.set_index, {OFFSET_BITS{1'b0}}};
          wdata_d = head.data[MEM_DATA_WIDTH-1:0];
        end
      end
      default: begin
        if (mem_wready) begin
          if (last_beat) begin
            pop     = 1'b1;
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_inc;
            wdata_d = head.data[beat_inc*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_wvalid = (state_q == ST_BURST);
  assign mem_wlast  = mem_wvalid && last_beat;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign empty      = fifo_empty && (state_q == ST_IDLE);

  // The head stays snoopable until its final beat is accepted.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    assign hit_vec[gi] = occupied[gi] &&
                         ({ent_tag[gi], ent_set[gi]} == snoop_addr[31:OFFSET_BITS]);
  end
  assign snoop_hit           = |hit_vec;
  assign snoop_offset_unused = ^snoop_addr[OFFSET_BITS-1:0];
endmodule

// File: tb/tb_mutative_writeback_buffer.sv
// Self-checking bench: a queue-based model of queued victims and expected beats
// runs every cycle, alongside table vectors and targeted multi-cycle sequences.
module tb_mutative_writeback_buffer;
  import mutative_writeback_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          evict_valid;
  logic          evict_ready;
  cache_output_t evict_line;
  logic [6:0]    evict_set;
  logic          mem_wvalid;
  logic          mem_wready;
  logic          mem_wlast;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [31:0]   snoop_addr;
  logic          snoop_hit;
  logic          empty;

  mutative_writeback_buffer #(.DEPTH(DEPTH), .MEM_DATA_WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evict_valid (evict_valid),
    .evict_ready (evict_ready),
    .evict_line  (evict_line),
    .evict_set   (evict_set),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_wlast   (mem_wlast),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .snoop_addr  (snoop_addr),
    .snoop_hit   (snoop_hit),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } line_t;

  line_t model_q[$];
  int    model_beat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [19:0] t, input logic [6:0] s);
    return {t, s, 5'b0};
  endfunction

  function automatic logic [255:0] mk_data(input logic [19:0] t, input logic [6:0] s);
    logic [255:0] r;
    for (int i = 0; i < 4; i++) r[i*64 +: 64] = {32'hD0D0_0000 + 32'(i), 5'b0, s, t};
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic model_snoop(input logic [31:0] a);
    foreach (model_q[i]) if (model_q[i].addr[31:5] == a[31:5]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: compare pre-edge outputs, then apply the coming edge.
  always @(negedge clk) begin
    int    sz;
    line_t ent;
    #2;
    if (!rst_n) begin
      model_q.delete();
      model_beat = 0;
    end else if (mon_en) begin
      sz = model_q.size();
      chk("evict_ready", evict_ready, sz < DEPTH);
      chk("empty", empty, sz == 0);
      chk("snoop_hit", snoop_hit, model_snoop(snoop_addr));
      if (sz == 0) begin
        chk("mem_wvalid_idle", mem_wvalid, 1'b0);
      end else if (mem_wvalid) begin
        chk("mem_addr", mem_addr, model_q[0].addr);
        chk("mem_wdata", mem_wdata, model_q[0].data[model_beat*64 +: 64]);
        chk("mem_wlast", mem_wlast, model_beat == 3);
      end
      if (mem_wvalid && mem_wready && sz > 0) begin
        model_beat++;
        if (model_beat == 4) begin
          void'(model_q.pop_front());
          model_beat = 0;
        end
      end
      if (evict_valid && sz < DEPTH && evict_line.valid && evict_line.dirty) begin
        ent.addr = addr_of(evict_line.tag, evict_set);
        ent.data = evict_line.data;
        model_q.push_back(ent);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic offer(input logic v, input logic d, input logic [19:0] t,
                       input logic [6:0] s, input logic [255:0] data);
    evict_valid = 1'b1;
    evict_line  = {v, d, t, data};
    evict_set   = s;
  endtask

  task automatic drain();
    int n;
    n = 0;
    evict_valid = 1'b0;
    mem_wready  = 1'b1;
    settle();
    while (!empty && n < 200) begin
      tick();
      settle();
      n++;
    end
    chk("drain_done", empty, 1'b1);
    tick();
  endtask

  typedef struct {
    logic        v;
    logic        d;
    logic [19:0] tag;
    logic [6:0]  set;
    int          exp_beats;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, first, acc, last_hs, seen, hs;
    logic [255:0] vd;
    logic [31:0]  p_addr;
    logic [63:0]  p_data;
    logic         p_last, p_stall;
    logic [19:0]  tags [3];
    logic [6:0]   sets [3];

    vecs[0] = '{1'b1, 1'b1, 20'hABCDE, 7'h05, 4, 32'hABCDE0A0};
    vecs[1] = '{1'b1, 1'b0, 20'hABCDE, 7'h05, 0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 20'h11111, 7'h01, 0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 20'h22222, 7'h02, 0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 20'h12345, 7'h7F, 4, 32'h12345FE0};
    tags = '{20'hABCDE, 20'h12345, 20'h00001};
    sets = '{7'h05, 7'h06, 7'h7F};

    rst_n = 1'b0; evict_valid = 1'b0; evict_line = '0; evict_set = '0;
    mem_wready = 1'b0; snoop_addr = '0;
    #3;
    chk("rst_evict_ready", evict_ready, 1'b1);
    chk("rst_mem_wvalid", mem_wvalid, 1'b0);
    chk("rst_mem_wlast", mem_wlast, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_snoop_hit", snoop_hit, 1'b0);
    chk("rst_empty", empty, 1'b1);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table vectors: one victim each, memory always ready.
    for (int k = 0; k < 5; k++) begin
      tick();
      mem_wready = 1'b1;
      vd = mk_data(vecs[k].tag, vecs[k].set);
      offer(vecs[k].v, vecs[k].d, vecs[k].tag, vecs[k].set, vd);
      settle();
      chk("vec_ready", evict_ready, 1'b1);
      tick();
      evict_valid = 1'b0;
      beats = 0;
      first = -1;
      for (int n = 0; n < 10; n++) begin
        settle();
        if (mem_wvalid) begin
          if (first < 0) first = n;
          chk("vec_addr", mem_addr, vecs[k].exp_addr);
          chk("vec_data", mem_wdata, vd[(beats % 4)*64 +: 64]);
          chk("vec_last", mem_wlast, beats == 3);
          beats++;
        end
        tick();
      end
      chk("vec_beats", beats, vecs[k].exp_beats);
      if (vecs[k].exp_beats > 0) chk("vec_latency", first, 1);
      settle();
      chk("vec_empty", empty, 1'b1);
    end

    // Snoop hit lifetime.
    tick();
    mem_wready = 1'b0;
    snoop_addr = 32'hABCDE0BF;
    offer(1'b1, 1'b1, 20'hABCDE, 7'h05, mk_data(20'hABCDE, 7'h05));
    tick();
    evict_valid = 1'b0;
    settle();
    chk("snoop_queued", snoop_hit, 1'b1);
    tick();
    snoop_addr = 32'hABCDE0C0;
    settle();
    chk("snoop_other_set", snoop_hit, 1'b0);
    tick();
    snoop_addr = 32'hABCDE0BF;
    mem_wready = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      settle();
      if (mem_wvalid && mem_wlast) begin
        chk("snoop_at_last", snoop_hit, 1'b1);
        seen = 1;
      end
      tick();
    end
    settle();
    chk("snoop_last_seen", seen, 1);
    chk("snoop_after_pop", snoop_hit, 1'b0);
    drain();

    // Fill with five dirty victims while memory is stalled.
    mem_wready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 1'b1, 20'h00010 + 20'(k), 7'h10 + 7'(k), mk_data(20'h00010 + 20'(k), 7'h10 + 7'(k)));
      settle();
      chk("fill_ready", evict_ready, 1'b1);
      tick();
    end
    offer(1'b1, 1'b1, 20'h00020, 7'h20, mk_data(20'h00020, 7'h20));
    for (int n = 0; n < 3; n++) begin
      settle();
      chk("full_stall", evict_ready, 1'b0);
      tick();
    end
    mem_wready = 1'b1;
    last_hs = -1;
    acc = -1;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      settle();
      if (mem_wvalid && mem_wready && mem_wlast && last_hs < 0) last_hs = n;
      if (evict_valid && evict_ready) acc = n;
      tick();
      if (acc >= 0) evict_valid = 1'b0;
    end
    chk("fifth_accept_cycle", acc, last_hs + 1);
    drain();

    // Backpressure mid-burst: ready pattern 1,0,0 repeating.
    offer(1'b1, 1'b1, 20'h3C3C3, 7'h2A, rand256());
    tick();
    evict_valid = 1'b0;
    beats = 0;
    p_stall = 1'b0;
    p_addr = '0; p_data = '0; p_last = 1'b0;
    for (int n = 0; n < 30; n++) begin
      mem_wready = (n % 3 == 0);
      settle();
      if (p_stall) begin
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_wdata", mem_wdata, p_data);
        chk("stall_wlast", mem_wlast, p_last);
      end
      p_stall = mem_wvalid && !mem_wready;
      p_addr  = mem_addr;
      p_data  = mem_wdata;
      p_last  = mem_wlast;
      if (mem_wvalid && mem_wready) beats++;
      tick();
    end
    chk("bp_beats", beats, 4);
    drain();

    // Asynchronous reset while beat 2 is on the bus.
    offer(1'b1, 1'b1, 20'h55555, 7'h33, mk_data(20'h55555, 7'h33));
    snoop_addr = 32'h55555660;
    tick();
    evict_valid = 1'b0;
    hs = 0;
    for (int n = 0; n < 20 && hs < 2; n++) begin
      settle();
      if (mem_wvalid && mem_wready) hs++;
      tick();
    end
    settle();
    chk("pre_reset_beat2", mem_wdata, mk_data(20'h55555, 7'h33) >> 128);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_evict_ready", evict_ready, 1'b1);
    chk("mid_rst_mem_wvalid", mem_wvalid, 1'b0);
    chk("mid_rst_mem_wlast", mem_wlast, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_mem_wdata", mem_wdata, 64'h0);
    chk("mid_rst_snoop_hit", snoop_hit, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      settle();
      chk("post_rst_no_burst", mem_wvalid, 1'b0);
      chk("post_rst_empty", empty, 1'b1);
      tick();
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      evict_valid = 1'($urandom_range(0, 1));
      evict_line  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                     tags[$urandom_range(0, 2)], rand256()};
      evict_set   = sets[$urandom_range(0, 2)];
      mem_wready  = ($urandom_range(0, 2) != 0);
      snoop_addr  = {tags[$urandom_range(0, 2)], sets[$urandom_range(0, 2)], 5'($urandom)};
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
